// File: rtl/axi4_lite_master.sv
// Purpose: turns single-beat core load/store requests into AXI4-Lite read/write transactions.
// Latency: zero-wait slave gives store accept N -> write_done N+3, load accept N -> data_valid N+3.
// Backpressure: one transaction in flight; busy stalls the core and new requests are ignored meanwhile.
module axi4_lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   // core side
   input  logic                      mem_read,
   input  logic                      mem_write,
   input  logic [DATA_WIDTH/8-1:0]   byte_en,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     write_data,
   output logic [DATA_WIDTH-1:0]     read_data,
   output logic                      data_valid,
   output logic                      write_done,
   output logic                      resp_err,
   output logic                      busy,
   // AXI4-Lite write address channel
   output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
   output logic                      m_awvalid_o,
   input  logic                      m_awready_i,
   // write data channel
   output logic [DATA_WIDTH-1:0]     m_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
   output logic                      m_wvalid_o,
   input  logic                      m_wready_i,
   // write response channel
   input  logic [1:0]                m_bresp_i,
   input  logic                      m_bvalid_i,
   output logic                      m_bready_o,
   // read address channel
   output logic [ADDR_WIDTH-1:0]     m_araddr_o,
   output logic                      m_arvalid_o,
   input  logic                      m_arready_i,
   // read data channel
   input  logic [DATA_WIDTH-1:0]     m_rdata_i,
   input  logic [1:0]                m_rresp_i,
   input  logic                      m_rvalid_i,
   output logic                      m_rready_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_RADDR,
      S_RDATA
   } state_e;

   state_e                    state_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic                      awvalid_q;
   logic                      wvalid_q;
   logic                      arvalid_q;
   logic                      bready_q;
   logic                      rready_q;
   logic [DATA_WIDTH-1:0]     read_data_q;
   logic                      data_valid_q;
   logic                      write_done_q;
   logic                      resp_err_q;
   logic                      busy_q;

   // The AW and W VALID registers double as the per-channel "not yet done" flags:
   // a channel stays pending after this cycle only if it is valid and not accepted.
   logic aw_pend_d;
   logic w_pend_d;

   assign aw_pend_d = awvalid_q & ~m_awready_i;
   assign w_pend_d  = wvalid_q  & ~m_wready_i;

   // Transaction FSM; every AXI and core-side output comes straight from a register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         rready_q     <= 1'b0;
         read_data_q  <= '0;
         data_valid_q <= 1'b0;
         write_done_q <= 1'b0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // completion pulses and their error qualifier last exactly one cycle
         data_valid_q <= 1'b0;
         write_done_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // a store takes priority; a simultaneous load is dropped
               if (mem_write) begin
                  addr_q    <= addr;
                  wdata_q   <= write_data;
                  wstrb_q   <= byte_en;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_WRITE;
               end else if (mem_read) begin
                  addr_q    <= addr;
                  arvalid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_RADDR;
               end
            end
            S_WRITE: begin
               // each VALID drops only on its own handshake, in any order
               awvalid_q <= aw_pend_d;
               wvalid_q  <= w_pend_d;
               if (!aw_pend_d && !w_pend_d) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (m_bvalid_i && bready_q) begin
                  bready_q     <= 1'b0;
                  write_done_q <= 1'b1;
                  resp_err_q   <= |m_bresp_i;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            S_RADDR: begin
               if (arvalid_q && m_arready_i) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (m_rvalid_i && rready_q) begin
                  rready_q     <= 1'b0;
                  read_data_q  <= m_rdata_i;
                  data_valid_q <= 1'b1;
                  resp_err_q   <= |m_rresp_i;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b0;
               arvalid_q <= 1'b0;
               bready_q  <= 1'b0;
               rready_q  <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign m_awaddr_o  = addr_q;
   assign m_awvalid_o = awvalid_q;
   assign m_wdata_o   = wdata_q;
   assign m_wstrb_o   = wstrb_q;
   assign m_wvalid_o  = wvalid_q;
   assign m_bready_o  = bready_q;
   assign m_araddr_o  = addr_q;
   assign m_arvalid_o = arvalid_q;
   assign m_rready_o  = rready_q;

   assign read_data   = read_data_q;
   assign data_valid  = data_valid_q;
   assign write_done  = write_done_q;
   assign resp_err    = resp_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: directed requests against a delay-programmable AXI4-Lite slave model.
// Expected completions are queued at issue time and checked by an independent monitor.
// Slave model also checks channel payloads and VALID/payload stability while stalled.
module tb_axi4_lite_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [3:0]  byte_en = '0;
   logic [31:0] addr = '0, write_data = '0;
   logic [31:0] read_data;
   logic        data_valid, write_done, resp_err, busy;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, arvalid, bready, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata = '0;

   axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en), .addr(addr),
      .write_data(write_data), .read_data(read_data), .data_valid(data_valid),
      .write_done(write_done), .resp_err(resp_err), .busy(busy),
      .m_awaddr_o(awaddr), .m_awvalid_o(awvalid), .m_awready_i(awready),
      .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_wvalid_o(wvalid), .m_wready_i(wready),
      .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
      .m_araddr_o(araddr), .m_arvalid_o(arvalid), .m_arready_i(arready),
      .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid), .m_rready_o(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errs   = 0;

   typedef struct packed {
      logic        is_wr;
      logic [31:0] data;
      logic        err;
      logic [31:0] due;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] aw_exp_q[$];
   logic [35:0] w_exp_q[$];
   logic [31:0] ar_exp_q[$];
   logic [31:0] last_rd = '0;

   // slave behaviour for the current transaction
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  bresp_cfg = '0, rresp_cfg = '0;
   logic [31:0] rdata_cfg = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // AXI4-Lite slave model: drives READY/response at negedges, checks payloads on each fire
   initial begin : slave
      bit aw_f, w_f, b_f, ar_f, r_f;
      bit aw_got, w_got, b_pend, r_pend;
      bit aw_st, w_st, ar_st;
      int aw_w, w_w, b_w, ar_w, r_w;
      logic [31:0] aw_prev, ar_prev;
      logic [35:0] w_prev;
      logic [31:0] ea;
      logic [35:0] ew;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_st = 0; w_st = 0; ar_st = 0;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      aw_prev = '0; ar_prev = '0; w_prev = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_st = 0; w_st = 0; ar_st = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = '0; rresp = '0; rdata = '0;
         end else begin
            // consequences of the handshakes at the last posedge
            if (aw_f) aw_got = 1;
            if (w_f) w_got = 1;
            if (b_f) begin b_pend = 0; aw_got = 0; w_got = 0; aw_w = 0; w_w = 0; end
            if (ar_f) begin r_pend = 1; r_w = 0; ar_w = 0; end
            if (r_f) r_pend = 0;
            if (aw_got && w_got && !b_pend) begin b_pend = 1; b_w = 0; end
            // stalled channels must keep VALID and payload
            if (aw_st) begin chk("awvalid_hold", awvalid, 1); chk("awaddr_stable", awaddr, aw_prev); end
            if (w_st) begin chk("wvalid_hold", wvalid, 1); chk("wdata_stable", {wstrb, wdata}, w_prev); end
            if (ar_st) begin chk("arvalid_hold", arvalid, 1); chk("araddr_stable", araddr, ar_prev); end
            // drive this cycle's slave outputs
            awready = awvalid && !aw_got && (aw_w >= aw_dly);
            if (awvalid && !aw_got) aw_w++;
            wready = wvalid && !w_got && (w_w >= w_dly);
            if (wvalid && !w_got) w_w++;
            bvalid = b_pend && (b_w >= b_dly);
            bresp  = bvalid ? bresp_cfg : 2'b00;
            if (b_pend) b_w++;
            arready = arvalid && !r_pend && (ar_w >= ar_dly);
            if (arvalid && !r_pend) ar_w++;
            rvalid = r_pend && (r_w >= r_dly);
            rdata  = rvalid ? rdata_cfg : 32'h0;
            rresp  = rvalid ? rresp_cfg : 2'b00;
            if (r_pend) r_w++;
            // handshakes that will occur at the next posedge
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            if (aw_f) begin
               if (aw_exp_q.size() == 0) begin
                  checks++; errs++; $display("FAIL unexpected_aw: actual=%0h required=none", awaddr);
               end else begin ea = aw_exp_q.pop_front(); chk("awaddr", awaddr, ea); end
            end
            if (w_f) begin
               if (w_exp_q.size() == 0) begin
                  checks++; errs++; $display("FAIL unexpected_w: actual=%0h required=none", wdata);
               end else begin ew = w_exp_q.pop_front(); chk("wstrb_wdata", {wstrb, wdata}, ew); end
            end
            if (ar_f) begin
               if (ar_exp_q.size() == 0) begin
                  checks++; errs++; $display("FAIL unexpected_ar: actual=%0h required=none", araddr);
               end else begin ea = ar_exp_q.pop_front(); chk("araddr", araddr, ea); end
            end
            if (b_f) chk("aw_w_idle_at_b", {awvalid, wvalid}, 2'b00);
            aw_st = awvalid && !awready; aw_prev = awaddr;
            w_st  = wvalid && !wready;   w_prev  = {wstrb, wdata};
            ar_st = arvalid && !arready; ar_prev = araddr;
         end
      end
   end

   // completion monitor: pops the scoreboard whenever the DUT reports a completion
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (data_valid || write_done) begin
               if (sb_q.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL unexpected_completion: actual dv=%0b wd=%0b required=none", data_valid, write_done);
               end else begin
                  e = sb_q.pop_front();
                  chk("completion_kind", {data_valid, write_done}, e.is_wr ? 2'b01 : 2'b10);
                  chk("completion_cycle", cyc, e.due);
                  chk("resp_err", resp_err, e.err);
                  if (!e.is_wr) last_rd = e.data;
                  chk("read_data", read_data, last_rd);
               end
            end else begin
               chk("resp_err_idle", resp_err, 0);
            end
         end
      end
   end

   // issue one request, then wait for busy to clear; optionally spam requests while busy
   task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int d1, input int d2, input int d3,
                         input logic [1:0] resp, input int lat, input bit spam);
      int n;
      int k;
      exp_t e;
      if (wr) begin
         aw_dly = d1; w_dly = d2; b_dly = d3; bresp_cfg = resp;
         aw_exp_q.push_back(a);
         w_exp_q.push_back({s, d});
      end else begin
         ar_dly = d1; r_dly = d2; rresp_cfg = resp; rdata_cfg = d;
         ar_exp_q.push_back(a);
      end
      n = cyc;
      e.is_wr = wr; e.data = d; e.err = (resp != 2'b00); e.due = n + lat;
      sb_q.push_back(e);
      mem_write = wr; mem_read = rd; addr = a; write_data = d; byte_en = s;
      @(negedge clk);
      chk("busy_after_accept", busy, 1);
      if (spam) begin
         mem_read = 1; mem_write = 1; addr = 32'h4000; write_data = 32'h99999999;
      end else begin
         mem_read = 0; mem_write = 0;
      end
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      mem_read = 0; mem_write = 0;
      if (busy) begin
         checks++; errs++;
         $display("FAIL busy_timeout: actual busy=1 required busy=0 after 100 cycles");
      end else begin
         chk("busy_release_cycle", cyc - n, lat);
      end
   endtask

   initial begin : stim
      // reset state
      rst = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {awvalid, wvalid, arvalid, bready, rready, busy, data_valid, write_done, resp_err}, 0);
      chk("reset_read_data", read_data, 0);
      #2 rst = 1;
      @(negedge clk);
      chk("idle_outputs", {awvalid, wvalid, arvalid, bready, rready, busy}, 0);

      // zero-wait store
      do_req(1, 0, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 3, 0);
      // load with 3-cycle ARREADY and 2-cycle RVALID delays
      do_req(0, 1, 32'h2004, 32'h12345678, 4'h0, 3, 2, 0, 2'b00, 8, 0);
      // AWREADY 4 cycles after WREADY, then the reverse
      do_req(1, 0, 32'h1008, 32'hA5A50F0F, 4'h3, 4, 0, 0, 2'b00, 7, 0);
      do_req(1, 0, 32'h100C, 32'h0BADF00D, 4'hC, 0, 4, 0, 2'b00, 7, 0);
      // read and write together: write wins; requests during busy ignored
      do_req(1, 1, 32'h3000, 32'h55AA55AA, 4'hF, 0, 0, 0, 2'b00, 3, 1);
      // error responses
      do_req(1, 0, 32'h1010, 32'h01020304, 4'h1, 0, 0, 0, 2'b10, 3, 0);
      do_req(0, 1, 32'h2008, 32'hCAFEF00D, 4'h0, 0, 0, 0, 2'b11, 3, 0);
      // clean load issued in the pulse cycle of the previous one
      do_req(0, 1, 32'h2000, 32'h00001111, 4'h0, 0, 0, 0, 2'b00, 3, 0);

      // reset while WVALID waits for WREADY
      aw_dly = 0; w_dly = 20; b_dly = 0; bresp_cfg = 2'b00;
      aw_exp_q.push_back(32'h1014);
      w_exp_q.push_back({4'hF, 32'h13572468});
      mem_write = 1; addr = 32'h1014; write_data = 32'h13572468; byte_en = 4'hF;
      @(negedge clk);
      mem_write = 0;
      repeat (2) @(negedge clk);
      chk("wvalid_waiting", {awvalid, wvalid, busy}, 3'b011);
      #2 rst = 0;
      #1;
      chk("abort_outputs", {awvalid, wvalid, arvalid, bready, rready, busy, data_valid, write_done, resp_err}, 0);
      chk("abort_read_data", read_data, 0);
      w_exp_q.delete();
      last_rd = '0;
      repeat (2) @(negedge clk);
      #2 rst = 1;
      @(negedge clk);
      do_req(0, 1, 32'h2010, 32'h77778888, 4'h0, 0, 0, 0, 2'b00, 3, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      chk("aw_exp_empty", aw_exp_q.size(), 0);
      chk("w_exp_empty", w_exp_q.size(), 0);
      chk("ar_exp_empty", ar_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
